asteroid_game_sequencer: RTL

- Game-level controller for the asteroid field datapath. Owns the row-advance timebase: drives the ROW sweep and RUNen consumed by the asteroid renderer.
- Detects asteroid/player collision on the bottom row, keeps score and shortens the row period as play progresses.
- Sits between the board inputs (start/pause buttons, player position) and the asteroid renderer / display mux.

---
 rtl/asteroid_game_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/asteroid_game_sequencer.sv
// Game-level controller: row-advance timebase, bottom-row collision, score, speed-up; optional high score via ASTEROID_HISCORE_EN.
// Latency: every output is a register updated one CLK edge after the inputs that cause it; RST clears all state asynchronously.
// Backpressure: none; PAUSE freezes the timebase and START is edge-detected internally.
module asteroid_game_sequencer #(
    parameter int TICK_DIV     = 1000,
    parameter int MIN_DIV      = 250,
    parameter int SPEEDUP_STEP = 50,
    parameter int SCORE_W      = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               PAUSE,
    input  logic [15:0]        PlayerCol,
    input  logic [15:0]        AstRow15,
    output logic [3:0]         ROW,
    output logic               RUNen,
    output logic [SCORE_W-1:0] SCORE,
    output logic               GAMEOVER,
    output logic [SCORE_W-1:0] HISCORE
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [TW-1:0] PERIOD_INIT = TW'(TICK_DIV);
    localparam logic [TW-1:0] PERIOD_MIN  = TW'(MIN_DIV);
    localparam logic [TW-1:0] PERIOD_STEP = TW'(SPEEDUP_STEP);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_PAUSED = 3'd2;
    localparam logic [2:0] ST_HIT    = 3'd3;
    localparam logic [2:0] ST_OVER   = 3'd4;

    logic [2:0]         state_q, state_n;
    logic               start_q;
    logic [TW-1:0]      tick_q, tick_n;
    logic [TW-1:0]      period_q, period_n;
    logic [3:0]         row_q, row_n;
    logic [SCORE_W-1:0] score_q, score_n;
    logic               runen_q;
    logic               over_q;

    logic               start_pulse;
    logic               hit;
    logic               row_done;
    logic [TW-1:0]      period_dec;

    assign start_pulse = START & ~start_q;
    assign hit         = |(AstRow15 & PlayerCol);
    assign row_done    = (tick_q == period_q - TW'(1));

    // Compare before subtracting so the period can never underflow below the floor.
    assign period_dec = (32'(period_q) >= 32'(MIN_DIV + SPEEDUP_STEP)) ?
                        (period_q - PERIOD_STEP) : PERIOD_MIN;

    always_comb begin
        state_n  = state_q;
        tick_n   = tick_q;
        period_n = period_q;
        row_n    = row_q;
        score_n  = score_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_pulse) begin
                    state_n  = ST_RUN;
                    tick_n   = '0;
                    period_n = PERIOD_INIT;
                    row_n    = 4'd0;
                    score_n  = '0;
                end
            end
            ST_RUN: begin
                if (hit) begin
                    state_n = ST_HIT;
                end else if (PAUSE) begin
                    state_n = ST_PAUSED;
                end else if (row_done) begin
                    tick_n = '0;
                    row_n  = row_q + 4'd1;
                    if (row_q == 4'd15) begin
                        score_n  = (&score_q) ? score_q : score_q + SCORE_W'(1);
                        period_n = period_dec;
                    end
                end else begin
                    tick_n = tick_q + TW'(1);
                end
            end
            ST_PAUSED: begin
                if (!PAUSE) begin
                    state_n = ST_RUN;
                end
            end
            ST_HIT: begin
                state_n = ST_OVER;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            tick_q   <= '0;
            period_q <= PERIOD_INIT;
            row_q    <= 4'd0;
            score_q  <= '0;
            runen_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            start_q  <= START;
            tick_q   <= tick_n;
            period_q <= period_n;
            row_q    <= row_n;
            score_q  <= score_n;
            runen_q  <= (state_n == ST_RUN);
            over_q   <= (state_n == ST_OVER);
        end
    end

    assign ROW      = row_q;
    assign RUNen    = runen_q;
    assign SCORE    = score_q;
    assign GAMEOVER = over_q;

`ifdef ASTEROID_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;

    // Survives restarts; only RST clears the best score.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hiscore_q <= '0;
        end else if (state_q == ST_HIT && score_q > hiscore_q) begin
            hiscore_q <= score_q;
        end
    end

    assign HISCORE = hiscore_q;
`else
    assign HISCORE = '0;
`endif

endmodule
